// File: rtl/bram_ctrl.sv
// Request/response front end for a single-port, read-first, one-cycle-latency block RAM.
// Optionally zero-fills the whole RAM after reset before it accepts host requests.
module bram_ctrl #(
    parameter int awidth         = 4,
    parameter int dwidth         = 8,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [awidth-1:0] req_addr,
    input  logic [dwidth-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [dwidth-1:0] rsp_data,
    output logic              mem_we,
    output logic [awidth-1:0] mem_addr,
    output logic [dwidth-1:0] mem_din,
    input  logic [dwidth-1:0] mem_dout,
    output logic              init_done
);

    typedef enum logic [2:0] {CLEAR, IDLE, ACCESS, WAIT, RESP} state_t;

    localparam state_t            RST_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
    localparam logic [awidth-1:0] LAST_ADDR = '1;

    state_t            state, state_nxt;
    logic              we_nxt;
    logic [awidth-1:0] addr_nxt;
    logic [dwidth-1:0] din_nxt;
    logic              rsp_valid_nxt;
    logic [dwidth-1:0] rsp_data_nxt;
    logic              init_done_nxt;

    always_comb begin
        state_nxt     = state;
        we_nxt        = mem_we;
        addr_nxt      = mem_addr;
        din_nxt       = mem_din;
        rsp_valid_nxt = rsp_valid;
        rsp_data_nxt  = rsp_data;
        init_done_nxt = init_done;
        case (state)
            CLEAR: begin
                // mem_we low marks the first fill cycle; the address then counts up and stops at the top
                if (!mem_we) begin
                    we_nxt   = 1'b1;
                    addr_nxt = '0;
                    din_nxt  = '0;
                end else if (mem_addr == LAST_ADDR) begin
                    we_nxt        = 1'b0;
                    init_done_nxt = 1'b1;
                    state_nxt     = IDLE;
                end else begin
                    addr_nxt = mem_addr + awidth'(1);
                end
            end
            IDLE: begin
                init_done_nxt = 1'b1;
                if (req_valid && req_ready) begin
                    addr_nxt  = req_addr;
                    we_nxt    = req_write;
                    if (req_write) din_nxt = req_wdata;
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                // mem_we still carries the request type during the RAM access cycle
                we_nxt    = 1'b0;
                state_nxt = mem_we ? IDLE : WAIT;
            end
            WAIT: begin
                rsp_data_nxt  = mem_dout;
                rsp_valid_nxt = 1'b1;
                state_nxt     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_nxt = 1'b0;
                    state_nxt     = IDLE;
                end
            end
            default: state_nxt = RST_STATE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RST_STATE;
            req_ready <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_din   <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            init_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            req_ready <= (state_nxt == IDLE);
            mem_we    <= we_nxt;
            mem_addr  <= addr_nxt;
            mem_din   <= din_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_data  <= rsp_data_nxt;
            init_done <= init_done_nxt;
        end
    end

endmodule

// File: tb/tb_bram_ctrl.sv
// Directed bench for bram_ctrl with a behavioural read-first RAM hung off the memory port.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_bram_ctrl;

    localparam int AW = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid, req_ready, req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;
    logic          init_done;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    bram_ctrl #(
        .awidth(AW),
        .dwidth(DW),
        .CLEAR_ON_RESET(1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data(rsp_data),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_din(mem_din),
        .mem_dout(mem_dout),
        .init_done(init_done)
    );

    // RAM preloaded with 0xEE so that a missing fill shows up on readback
    logic [DW-1:0] ram [2**AW];
    logic          ram_seeded = 1'b0;

    always @(posedge clk) begin
        if (!ram_seeded) begin
            for (int i = 0; i < 2**AW; i++) ram[i] <= 8'hEE;
            ram_seeded <= 1'b1;
        end else if (mem_we) begin
            ram[mem_addr] <= mem_din;
        end
        mem_dout <= ram[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 100) begin
            tick();
            n++;
        end
        check("req_ready_timeout", 32'(req_ready), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_we"},    32'(mem_we),    32'd0);
        check({tag, "_addr"},  32'(mem_addr),  32'd0);
        check({tag, "_din"},   32'(mem_din),   32'd0);
        check({tag, "_rdy"},   32'(req_ready), 32'd0);
        check({tag, "_rspv"},  32'(rsp_valid), 32'd0);
        check({tag, "_rspd"},  32'(rsp_data),  32'd0);
        check({tag, "_idone"}, 32'(init_done), 32'd0);
    endtask

    // Reset must be released 1 unit after an edge; the next edge is fill edge 1
    task automatic check_fill();
        for (int i = 0; i < 2**AW; i++) begin
            tick();
            check("fill_we",   32'(mem_we),    32'd1);
            check("fill_addr", 32'(mem_addr),  32'(i));
            check("fill_din",  32'(mem_din),   32'd0);
            check("fill_rdy",  32'(req_ready), 32'd0);
            check("fill_idone", 32'(init_done), 32'd0);
        end
        tick();
        check("fill_end_we",    32'(mem_we),    32'd0);
        check("fill_end_idone", 32'(init_done), 32'd1);
        check("fill_end_rdy",   32'(req_ready), 32'd1);
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wait_ready();
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = a;
        req_wdata = d;
        tick();
        req_valid = 1'b0;
        check("wr_we",   32'(mem_we),    32'd1);
        check("wr_addr", 32'(mem_addr),  32'(a));
        check("wr_din",  32'(mem_din),   32'(d));
        check("wr_rdy",  32'(req_ready), 32'd0);
        tick();
        check("wr_we_off", 32'(mem_we),    32'd0);
        check("wr_rdy_on", 32'(req_ready), 32'd1);
        check("wr_norsp",  32'(rsp_valid), 32'd0);
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] e, input int hold);
        wait_ready();
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = a;
        req_wdata = 8'h5A;
        rsp_ready = (hold == 0);
        tick();
        req_valid = 1'b0;
        check("rd_we",   32'(mem_we),    32'd0);
        check("rd_addr", 32'(mem_addr),  32'(a));
        check("rd_rdy",  32'(req_ready), 32'd0);
        tick();
        check("rd_e1_rspv", 32'(rsp_valid), 32'd0);
        tick();
        check("rd_e2_rspv", 32'(rsp_valid), 32'd1);
        check("rd_e2_data", 32'(rsp_data),  32'(e));
        check("rd_e2_rdy",  32'(req_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            tick();
            check("bp_rspv", 32'(rsp_valid), 32'd1);
            check("bp_data", 32'(rsp_data),  32'(e));
            check("bp_rdy",  32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("rd_hs_rspv", 32'(rsp_valid), 32'd0);
        check("rd_hs_rdy",  32'(req_ready), 32'd1);
        check("rd_hs_data", 32'(rsp_data),  32'(e));
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b0;
        repeat (3) tick();
        check_all_zero("rst");

        rst_n = 1'b1;
        check_fill();
        do_read(4'd5, 8'h00, 0);

        do_write(4'd3, 8'hA5);
        do_read(4'd3, 8'hA5, 0);
        do_read(4'd3, 8'hA5, 5);

        do_write(4'd15, 8'hFF);
        do_write(4'd0,  8'h01);
        do_read(4'd15, 8'hFF, 0);
        do_read(4'd0,  8'h01, 0);
        do_read(4'd7,  8'h00, 0);
        do_read(4'd14, 8'h00, 0);
        do_read(4'd1,  8'h00, 0);

        // Read of addr 3 interrupted by reset while the controller sits in WAIT
        wait_ready();
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 4'd3;
        rsp_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        check("mid_pre_rdy", 32'(req_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_rst");

        // Read of addr 7 held through the whole refill
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 4'd7;
        rsp_ready = 1'b0;
        tick();
        check_all_zero("mid_rst_hold");
        rst_n = 1'b1;
        check_fill();
        tick();
        req_valid = 1'b0;
        check("held_acc_addr", 32'(mem_addr),  32'd7);
        check("held_acc_we",   32'(mem_we),    32'd0);
        check("held_acc_rdy",  32'(req_ready), 32'd0);
        tick();
        check("held_e1_rspv", 32'(rsp_valid), 32'd0);
        tick();
        check("held_e2_rspv", 32'(rsp_valid), 32'd1);
        check("held_e2_data", 32'(rsp_data),  32'h00);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("held_hs_rspv", 32'(rsp_valid), 32'd0);
        check("held_hs_rdy",  32'(req_ready), 32'd1);

        do_read(4'd3,  8'h00, 0);
        do_read(4'd15, 8'h00, 0);
        do_read(4'd0,  8'h00, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bram_ctrl.md
Name: bram_ctrl

Overview:
- Initiator/controller for the single-port, read-first, one-cycle-latency block RAM (we/addr/din in, registered dout out).
- Converts a valid/ready request stream (read or write) into correctly timed RAM cycles and returns read data on a valid/ready response channel.
- Optionally zero-fills the whole RAM after reset.
- Sits between a host FSM or UART command decoder and the RAM instance.

Parameters:
- awidth, 4, RAM address width; depth = 2**awidth.
- dwidth, 8, RAM data width.
- CLEAR_ON_RESET, 1, 1 = zero-fill all RAM locations after reset before accepting requests; 0 = skip the fill.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  host request present.
- req_ready  out  1  controller can accept a request this cycle.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  awidth  target address.
- req_wdata  in  dwidth  write data; ignored for reads.
- rsp_valid  out  1  read data available.
- rsp_ready  in  1  host accepts the response.
- rsp_data  out  dwidth  read data.
- mem_we  out  1  to RAM we.
- mem_addr  out  awidth  to RAM addr.
- mem_din  out  dwidth  to RAM din.
- mem_dout  in  dwidth  from RAM dout (registered inside RAM).
- init_done  out  1  fill sequence complete; stays 1 until the next reset.

Behaviour:
- Interface:
  - One clock, clk.
  - Reset rst_n is asynchronous and active-low.
  - All outputs are registered. Every output is 0 while rst_n = 0.
- State machine: CLEAR, IDLE, ACCESS, WAIT, RESP.
  - Reset state is CLEAR if CLEAR_ON_RESET = 1, otherwise IDLE.
- CLEAR:
  - mem_we = 1 and mem_din = 0.
  - mem_addr steps 0, 1, ... 2**awidth-1, one address per cycle; the first write edge is the first rising edge after reset release.
  - Exactly 2**awidth write cycles.
  - On the edge after the last address: mem_we <= 0, init_done <= 1, go to IDLE.
- With CLEAR_ON_RESET = 0: init_done <= 1 on the first edge after reset release.
- req_ready:
  - Updated every edge as req_ready <= (next_state == IDLE).
  - Therefore 0 during reset, CLEAR, ACCESS, WAIT and RESP.
  - Rises on the edge that enters IDLE.
  - Requests with req_ready = 0 are ignored, with no side effects.
- IDLE:
  - Acceptance occurs on an edge E0 where req_valid & req_ready = 1.
  - At E0: mem_addr <= req_addr, mem_din <= req_wdata (writes only), mem_we <= req_write; go to ACCESS.
- ACCESS (edge E1): the RAM samples its inputs at this edge.
  - Write: mem_we <= 0, go to IDLE. Writes produce no response. Write throughput is 1 per 2 cycles.
  - Read: go to WAIT. The RAM's dout updates at E1.
- WAIT (edge E2): rsp_data <= mem_dout, rsp_valid <= 1, go to RESP.
  - rsp_valid is high 2 edges after acceptance.
- RESP:
  - rsp_valid and rsp_data are held stable while rsp_ready = 0.
  - On the edge with rsp_valid & rsp_ready: rsp_valid <= 0, go to IDLE. req_ready is 1 in the following cycle.
  - rsp_data retains its last value after the handshake.
- Only one request is outstanding at a time; there is no pipelining.
- Address handling: mem_addr is driven exactly as received. No arithmetic is applied outside CLEAR. The CLEAR counter stops at 2**awidth-1 and does not wrap.
- mem_we is 1 only during CLEAR and the single ACCESS cycle of a write.
- Reset mid-operation, in any state:
  - All outputs clear immediately, including mem_we, rsp_valid and init_done.
  - An in-flight request is discarded.
  - CLEAR restarts from address 0 after release if enabled.
- If req_valid is held throughout CLEAR, it is accepted on the first IDLE edge.

Test Plan:
- Fill (awidth=4, dwidth=8, CLEAR_ON_RESET=1): release rst_n -> mem_we=1 for exactly 16 cycles, mem_addr 0..15, mem_din=0. init_done=1 and req_ready=1 after edge 17. Then read addr 5 -> rsp_data=0x00.
- Write then read: write 0xA5 to addr 3, then read addr 3 -> mem_we is high for one cycle only; rsp_valid rises 2 edges after read acceptance with rsp_data=0xA5.
- Backpressure: read addr 3 with rsp_ready=0 for 5 cycles -> rsp_valid=1 and rsp_data=0xA5 held stable, req_ready=0. Raise rsp_ready -> rsp_valid falls at that edge and req_ready=1 the next cycle.
- Address extremes: write 0xFF to addr 15 and 0x01 to addr 0, then read 15 and 0 -> 0xFF and 0x01; other locations still 0x00.
- Held request during CLEAR: req_valid=1, read addr 7 from reset release -> no extra RAM cycles during the fill; request accepted on the first IDLE edge; rsp_data=0x00.
- Reset mid-read: drop rst_n while in WAIT -> all outputs 0 immediately. After release the fill reruns, and a read of the previously written addr 3 returns 0x00.
